sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one synchronous single-port SRAM between an instruction-fetch
//   requester (read-only) and a load/store requester.  Requests are accepted
//   combinationally (addr_ok in the same cycle as req) and the response is
//   returned exactly one cycle later, when the SRAM read data is valid.
//   Data requests normally win.  A starve counter ensures that a waiting
//   instruction fetch gets the port after STARVE_LIMIT consecutive data grants.
//
// Ports
//   clk, reset          : single clock, asynchronous active-high reset
//   inst_req/inst_addr  : fetch request; inst_addr_ok = accepted this cycle
//   inst_data_ok/rdata  : fetch response, one cycle after acceptance
//   data_req/wr/wstrb/addr/wdata : load/store request
//   data_addr_ok        : load/store accepted this cycle
//   data_data_ok/rdata  : load/store response (rdata is 0 for stores)
//   sram_en/we/addr/wdata/rdata : shared SRAM port, rdata valid the cycle after en
module sram_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   // instruction requester
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // data requester
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // shared SRAM port
   output logic        sram_en,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   // Which requester owns the SRAM read data in the current cycle.
   typedef enum logic [1:0] {
      IDLE,
      RESP_I,
      RESP_D
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic       wr_q, wr_d;       // granted data request was a store

   logic       starved;
   logic       inst_grant;
   logic       data_grant;

   // ------------------------------------------------------------------
   // Grant decision.  Gated by reset so nothing is accepted while the
   // block is held in reset, even though the reset itself is asynchronous.
   // ------------------------------------------------------------------
   always_comb begin
      starved    = (starve_q == LIMIT);
      inst_grant = !reset && inst_req && (!data_req || starved);
      data_grant = !reset && data_req && !inst_grant;
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         starve_q <= '0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         wr_q     <= wr_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = IDLE;
      starve_d = starve_q;
      wr_d     = wr_q;

      if (inst_grant) begin
         state_d = RESP_I;
      end else if (data_grant) begin
         state_d = RESP_D;
         wr_d    = data_wr;
      end

      // Counts data grants that overtook a waiting fetch; any cycle
      // without a fetch pending, or a fetch grant, restarts the count.
      if (!inst_req || inst_grant) begin
         starve_d = '0;
      end else if (data_grant && !starved) begin
         starve_d = starve_q + 4'd1;
      end
   end

   // ------------------------------------------------------------------
   // Output logic: request side follows the grant, response side
   // follows the registered owner of this cycle's SRAM read data.
   // ------------------------------------------------------------------
   always_comb begin
      inst_addr_ok = inst_grant;
      data_addr_ok = data_grant;

      sram_en    = 1'b0;
      sram_we    = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (inst_grant) begin
         sram_en   = 1'b1;
         sram_addr = inst_addr;
      end else if (data_grant) begin
         sram_en    = 1'b1;
         sram_addr  = data_addr;
         sram_we    = data_wr ? data_wstrb : 4'b0000;
         sram_wdata = data_wdata;
      end

      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      data_data_ok = 1'b0;
      data_rdata   = '0;
      case (state_q)
         RESP_I: begin
            inst_data_ok = 1'b1;
            inst_rdata   = sram_rdata;
         end
         RESP_D: begin
            data_data_ok = 1'b1;
            data_rdata   = wr_q ? 32'h0 : sram_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Drives sram_port_arbiter with directed scenarios and randomized traffic,
//   with a behavioural SRAM on the shared port and a reference model of the
//   arbitration and response rules.
module tb_sram_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr, sram_wdata, sram_rdata;

   always #5 clk = ~clk;

   sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .sram_en      (sram_en),
      .sram_we      (sram_we),
      .sram_addr    (sram_addr),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata)
   );

   // Behavioural synchronous SRAM (16 words, indexed by addr[5:2]).
   logic [31:0] sram_mem [16];
   logic [31:0] rd_q = '0;
   always @(posedge clk) begin
      if (sram_en) begin
         rd_q <= sram_mem[sram_addr[5:2]];
         for (int b = 0; b < 4; b++)
            if (sram_we[b]) sram_mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
   end
   assign sram_rdata = rd_q;

   // Reference model state
   logic [31:0] ref_mem [16];
   int          starve;      // data grants since the fetch started waiting
   int          resp_kind;   // 0 none, 1 fetch response, 2 load/store response
   logic [31:0] resp_val;
   logic        last_ig, last_dg;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      starve    = 0;
      resp_kind = 0;
      resp_val  = '0;
   endtask

   // Checks this cycle's outputs against the model, then advances the model
   // to the state the next rising edge will commit.
   task automatic step_check();
      logic        ig, dg;
      logic [3:0]  idx, ewe;
      logic [31:0] ea, ew;
      check("inst_data_ok", 32'(inst_data_ok), 32'(resp_kind == 1));
      check("inst_rdata",   inst_rdata, (resp_kind == 1) ? resp_val : 32'h0);
      check("data_data_ok", 32'(data_data_ok), 32'(resp_kind == 2));
      check("data_rdata",   data_rdata, (resp_kind == 2) ? resp_val : 32'h0);

      ig = !reset && inst_req && (!data_req || starve == LIMIT);
      dg = !reset && data_req && !ig;
      last_ig = ig;
      last_dg = dg;
      ea  = ig ? inst_addr : (dg ? data_addr : 32'h0);
      ewe = (dg && data_wr) ? data_wstrb : 4'h0;
      ew  = dg ? data_wdata : 32'h0;
      check("inst_addr_ok", 32'(inst_addr_ok), 32'(ig));
      check("data_addr_ok", 32'(data_addr_ok), 32'(dg));
      check("sram_en",      32'(sram_en), 32'(ig || dg));
      check("sram_addr",    sram_addr, ea);
      check("sram_we",      32'(sram_we), 32'(ewe));
      check("sram_wdata",   sram_wdata, ew);

      if (reset) begin
         model_reset();
      end else begin
         if (!inst_req || ig) starve = 0;
         else if (dg && starve < LIMIT) starve++;
         resp_kind = ig ? 1 : (dg ? 2 : 0);
         if (ig) begin
            idx = inst_addr[5:2];
            resp_val = ref_mem[idx];
         end else if (dg) begin
            idx = data_addr[5:2];
            if (data_wr) begin
               resp_val = '0;
               for (int b = 0; b < 4; b++)
                  if (data_wstrb[b]) ref_mem[idx][8*b +: 8] = data_wdata[8*b +: 8];
            end else begin
               resp_val = ref_mem[idx];
            end
         end
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd);
      inst_req   = ir;
      inst_addr  = ia;
      data_req   = dr;
      data_wr    = dw;
      data_wstrb = ds;
      data_addr  = da;
      data_wdata = dd;
   endtask

   task automatic inst_only_scenario();
      @(negedge clk);
      drive(1'b1, 32'h1c000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 step_check();
      check("fetch_accept", 32'(inst_addr_ok), 32'h1);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 step_check();
      check("fetch_resp_ok", 32'(inst_data_ok), 32'h1);
      check("fetch_resp_data", inst_rdata, 32'h02800400);
   endtask

   initial begin
      logic [31:0] v;
      for (int i = 0; i < 16; i++) begin
         v = $urandom();
         sram_mem[i] = v;
         ref_mem[i]  = v;
      end
      sram_mem[0] = 32'h02800400;
      ref_mem[0]  = 32'h02800400;
      model_reset();

      // Reset state with both requesters active
      reset = 1'b1;
      drive(1'b1, 32'h1c000000, 1'b1, 1'b0, 4'h0, 32'h00001000, 32'h0);
      #1 step_check();
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      reset = 1'b0;
      #1 step_check();

      // Fetch only
      inst_only_scenario();

      // Conflict: data wins, fetch retried next cycle
      @(negedge clk);
      drive(1'b1, 32'h1c000004, 1'b1, 1'b0, 4'h0, 32'h00001000, 32'h0);
      #1 step_check();
      check("conflict_data_ok", 32'(data_addr_ok), 32'h1);
      check("conflict_inst_blocked", 32'(inst_addr_ok), 32'h0);
      check("conflict_sram_addr", sram_addr, 32'h00001000);
      @(negedge clk);
      drive(1'b1, 32'h1c000004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 step_check();
      check("conflict_data_resp", 32'(data_data_ok), 32'h1);
      check("conflict_inst_retry", 32'(inst_addr_ok), 32'h1);

      // Store
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h00000010, 32'hdeadbeef);
      #1 step_check();
      check("store_we", 32'(sram_we), 32'h3);
      check("store_wdata", sram_wdata, 32'hdeadbeef);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 step_check();
      check("store_resp_ok", 32'(data_data_ok), 32'h1);
      check("store_resp_data", data_rdata, 32'h0);

      // Starvation: both held, four data grants then one fetch grant
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         drive(1'b1, 32'h1c000008, 1'b1, 1'b0, 4'h0, 32'h00000020, 32'h0);
         #1 step_check();
         check("starve_pattern", 32'(inst_addr_ok), 32'((k % 5) == 4));
      end

      // Reset while a load response is pending
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 step_check();
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h00000020, 32'h0);
      #1 step_check();
      check("rst_pre_grant", 32'(data_addr_ok), 32'h1);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("rst_async_addr_ok", 32'(data_addr_ok), 32'h0);
      check("rst_async_sram_en", 32'(sram_en), 32'h0);
      check("rst_async_sram_addr", sram_addr, 32'h0);
      @(negedge clk);
      #1 step_check();
      check("rst_no_resp", 32'(data_data_ok), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 step_check();
      check("rst_release_no_resp", 32'(data_data_ok), 32'h0);
      inst_only_scenario();

      // Randomized traffic; unaccepted requests are held stable
      last_ig = 1'b1;
      last_dg = 1'b1;
      inst_req = 1'b0;
      data_req = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!inst_req || last_ig) begin
            inst_req  = ($urandom_range(0, 3) != 0);
            inst_addr = $urandom() & 32'hFFFF_FFFC;
         end
         if (!data_req || last_dg) begin
            data_req   = ($urandom_range(0, 2) != 0);
            data_wr    = $urandom_range(0, 1) == 1;
            data_wstrb = 4'($urandom_range(0, 15));
            data_addr  = $urandom() & 32'hFFFF_FFFC;
            data_wdata = $urandom();
         end
         #1 step_check();
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
